alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake, an architectural {Z,C,V,N} flag register and an optional multiply.
// Latency: 1 cycle for single-cycle ops. MUL takes MUL_CYCLES cycles when ALU_PIPE_MUL_EN is defined.
// Backpressure: in_ready drops while a multiply is busy, or while a result is held because out_ready is low.
//
// Build option: define ALU_PIPE_MUL_EN to make op 1010 an iterative shift-add multiply.
// Without it, op 1010 is treated as an undefined op: result 0, status Z=1.
module alu_pipe #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       op_code,
   input  logic             s_update,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       status,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1010;

   // Bit positions inside status/flags, which are both ordered {Z,C,V,N}.
   localparam int F_Z = 3;
   localparam int F_C = 2;
   localparam int F_V = 1;
   localparam int F_N = 0;

   logic             busy_q;
   logic             accept;
   logic             is_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;
   logic [3:0]       mul_status;
   logic             mul_upd;

   logic             add_cin;
   logic             sub_cin;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [3:0]       alu_status;

   // A new request may enter only when no multiply is running and the output slot is free or draining.
   assign in_ready = !busy_q && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = busy_q;

   // Subtraction is A + ~B + cin, so the carry out is NOT borrow.
   // SBC feeds in the live C flag, which gives A - B - !C.
   always_comb begin
      add_cin = (op_code == OP_ADC) ? flags[F_C] : 1'b0;
      sub_cin = (op_code == OP_SBC) ? flags[F_C] : 1'b1;
      add_sum = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, add_cin};
      sub_sum = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, sub_cin};
   end

   // Single-cycle result and carry/overflow selection.
   // Logical ops, moves and unknown codes leave C and V clear.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_code)
         OP_MOV: alu_res = b_in;
         OP_MVN: alu_res = ~b_in;
         OP_ADD, OP_ADC: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_sum[WIDTH-1] != a_in[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            alu_res = sub_sum[WIDTH-1:0];
            alu_c   = sub_sum[WIDTH];
            alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_sum[WIDTH-1] != a_in[WIDTH-1]);
         end
         OP_AND:  alu_res = a_in & b_in;
         OP_ORR:  alu_res = a_in | b_in;
         OP_EOR:  alu_res = a_in ^ b_in;
         default: alu_res = '0;
      endcase
      alu_status = {(alu_res == '0), alu_c, alu_v, alu_res[WIDTH-1]};
   end

`ifdef ALU_PIPE_MUL_EN
   localparam int CW = $clog2(MUL_CYCLES + 1);

   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_acc_nxt;
   logic [WIDTH-1:0] mul_mcand;
   logic [WIDTH-1:0] mul_mplier;
   logic [CW-1:0]    mul_cnt;
   logic             mul_upd_q;
   logic             mul_last;
   logic             mul_step;

   assign is_mul = (op_code == OP_MUL);

   // One partial product per cycle. The final step is taken only when the output slot can accept
   // the product, so a stalled consumer keeps the multiplier parked with busy high.
   always_comb begin
      mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
      mul_last    = busy_q && (mul_cnt == CW'(1));
      mul_done    = mul_last && (!out_valid || out_ready);
      mul_step    = busy_q && (!mul_last || mul_done);
      mul_res     = mul_acc_nxt;
      mul_upd     = mul_upd_q;
   end

   // Multiplier state: loaded on accept, stepped once per busy cycle, released on the completion edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         mul_cnt    <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_upd_q  <= 1'b0;
      end else if (accept && is_mul) begin
         busy_q     <= 1'b1;
         mul_cnt    <= CW'(MUL_CYCLES);
         mul_acc    <= '0;
         mul_mcand  <= a_in;
         mul_mplier <= b_in;
         mul_upd_q  <= s_update;
      end else if (mul_step) begin
         mul_acc    <= mul_acc_nxt;
         mul_mcand  <= mul_mcand << 1;
         mul_mplier <= mul_mplier >> 1;
         mul_cnt    <= mul_cnt - CW'(1);
         if (mul_done) begin
            busy_q <= 1'b0;
         end
      end
   end
`else
   // Without the multiplier, op 1010 takes the single-cycle path and falls into the undefined-op case.
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
   assign mul_upd  = 1'b0;

   // The multiplier is absent, so busy_q stays at its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= 1'b0;
      end
   end
`endif

   // A multiply reports Z and N from its product. C and V are carried through from the current flags.
   assign mul_status = {(mul_res == '0), flags[F_C], flags[F_V], mul_res[WIDTH-1]};

   // Output slot: load on a single-cycle accept or on multiply completion, otherwise drain when consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         status    <= '0;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         result    <= alu_res;
         status    <= alu_status;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         result    <= mul_res;
         status    <= mul_status;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Architectural flags: written by an op that requested it.
   // A back-to-back ADC/SBC therefore sees the new carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (accept && !is_mul && s_update) begin
         flags <= alu_status;
      end else if (mul_done && mul_upd) begin
         flags <= mul_status;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
module tb_alu_pipe;
   localparam int W = 32;

   localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011;
   localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101, AND_ = 4'b0110, ORR = 4'b0111;
   localparam logic [3:0] EOR = 4'b1000, MUL = 4'b1010;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic [3:0]    op_code = '0;
   logic          s_update = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic [3:0]    status;
   logic [3:0]    flags;
   logic          busy;

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .op_code(op_code), .s_update(s_update),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .status(status), .flags(flags), .busy(busy)
   );

   // Narrow instance for the 8-bit boundary case.
   logic          in_valid8 = 1'b0;
   logic          in_ready8;
   logic [7:0]    a8 = '0;
   logic [7:0]    b8 = '0;
   logic [3:0]    op8 = '0;
   logic          upd8 = 1'b0;
   logic          out_valid8;
   logic          out_ready8 = 1'b1;
   logic [7:0]    result8;
   logic [3:0]    status8;
   logic [3:0]    flags8;
   logic          busy8;

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a_in(a8), .b_in(b8), .op_code(op8), .s_update(upd8),
      .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .status(status8), .flags(flags8), .busy(busy8)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU over integers: returns {status, result}.
   // Overflow is decided by the signed value leaving the representable range.
   function automatic logic [W+3:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [3:0] fl);
      longint unsigned ua, ub, uf;
      longint sa, sb, ss, full, smax, smin;
      logic [W-1:0] r;
      logic c, v;
      int ci;
      ua = a;
      ub = b;
      sa = a[W-1] ? longint'(ua) - (longint'(1) << W) : longint'(ua);
      sb = b[W-1] ? longint'(ub) - (longint'(1) << W) : longint'(ub);
      smax = (longint'(1) << (W-1)) - 1;
      smin = -(longint'(1) << (W-1));
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         MOV: r = b;
         MVN: r = ~b;
         ADD, ADC: begin
            ci = (op == ADC && fl[2]) ? 1 : 0;
            uf = ua + ub + longint'(ci);
            r  = uf[W-1:0];
            c  = uf[W];
            ss = sa + sb + longint'(ci);
            v  = (ss > smax) || (ss < smin);
         end
         SUB, SBC: begin
            ci   = (op == SBC && !fl[2]) ? 1 : 0;
            full = longint'(ua) - longint'(ub) - longint'(ci);
            r    = full[W-1:0];
            c    = (full >= 0);
            ss   = sa - sb - longint'(ci);
            v    = (ss > smax) || (ss < smin);
         end
         AND_: r = a & b;
         ORR:  r = a | b;
         EOR:  r = a ^ b;
         default: r = '0;
      endcase
      return {(r == '0), c, v, r[W-1], r};
   endfunction

   // Transaction-level model: output slot, flag register, and remaining multiply cycles.
   logic          m_valid = 1'b0, m_busy = 1'b0, m_upd = 1'b0;
   logic [W-1:0]  m_res = '0, m_prod = '0;
   logic [3:0]    m_stat = '0, m_flags = '0;
   int            m_cnt = 0;
   logic          pv, rdy, nv;
   logic [W+3:0]  rr;
   longint unsigned prod64;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0; m_busy = 1'b0; m_res = '0; m_stat = '0; m_flags = '0; m_cnt = 0;
      end else begin
         pv  = m_valid;
         rdy = !m_busy && (!m_valid || out_ready);
         nv  = pv && !out_ready;
         if (m_busy) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (!pv || out_ready) begin
               nv = 1'b1;
               m_res  = m_prod;
               m_stat = {(m_prod == '0), m_flags[2], m_flags[1], m_prod[W-1]};
               if (m_upd) m_flags = m_stat;
               m_busy = 1'b0;
            end
         end
         if (in_valid && rdy) begin
`ifdef ALU_PIPE_MUL_EN
            if (op_code == MUL) begin
               prod64 = longint'(a_in) * longint'(b_in);
               m_prod = prod64[W-1:0];
               m_busy = 1'b1;
               m_cnt  = W;
               m_upd  = s_update;
            end else
`endif
            begin
               rr = ref_alu(op_code, a_in, b_in, m_flags);
               nv = 1'b1;
               m_res  = rr[W-1:0];
               m_stat = rr[W+3:W];
               if (s_update) m_flags = m_stat;
            end
         end
         m_valid = nv;
      end
   end

   // Per-cycle compare of every observable output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", in_ready, !m_busy && (!m_valid || out_ready));
         check("out_valid", out_valid, m_valid);
         check("busy", busy, m_busy);
         check("flags", flags, m_flags);
         if (m_valid) begin
            check("result", result, m_res);
            check("status", status, m_stat);
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic upd);
      in_valid = 1'b1; op_code = op; a_in = a; b_in = b; s_update = upd;
      @(posedge clk); #1;
      in_valid = 1'b0; s_update = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check("mul_finish_bound", busy, 1'b0);
   endtask

   logic [3:0]  t_op [13] = '{MOV, MVN, AND_, ORR, EOR, ADD, ADC, SBC, SUB, SBC, 4'b0000, 4'b1111, ADD};
   logic [31:0] t_a  [13] = '{32'h0, 32'h0, 32'hF0F0F0F0, 32'h0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h10,
                              32'h10, 32'h0, 32'h80000000, 32'h5, 32'h5, 32'h80000000};
   logic [31:0] t_b  [13] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hFF00FF00, 32'h0, 32'h55555555, 32'h1, 32'h20,
                              32'h20, 32'h1, 32'h0, 32'h5, 32'h5, 32'h80000000};
   logic        t_upd[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      int seen;
      int nb;

      // Pin the reference model with hand-computed values.
      check("model_add_ovf", ref_alu(ADD, 32'h7FFFFFFF, 32'h1, 4'h0), {4'b0011, 32'h80000000});
      check("model_sub_borrow", ref_alu(SUB, 32'h0, 32'h1, 4'h0), {4'b0001, 32'hFFFFFFFF});
      check("model_sbc_ovf", ref_alu(SBC, 32'h80000000, 32'h0, 4'h0), {4'b0110, 32'h7FFFFFFF});
      check("model_adc_cin", ref_alu(ADC, 32'h1, 32'h1, 4'b0100), {4'b0000, 32'h3});

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_status", status, 4'h0);
      check("rst_flags", flags, 4'h0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_release", in_ready, 1'b1);
      @(posedge clk); #1;

      // Signed overflow on ADD; the flags take the same value as the status.
      issue(ADD, 32'h7FFFFFFF, 32'h1, 1'b1);
      check("add_ovf_result", result, 32'h80000000);
      check("add_ovf_status", status, 4'b0011);
      check("add_ovf_flags", flags, 4'b0011);

      // SUB sets C, and a back-to-back ADC consumes it.
      issue(SUB, 32'h5, 32'h5, 1'b1);
      check("sub_eq_status", status, 4'b1100);
      issue(ADC, 32'h1, 32'h1, 1'b0);
      check("adc_chain_result", result, 32'h3);

      // Directed table, checked cycle by cycle against the model.
      for (int i = 0; i < 13; i++) issue(t_op[i], t_a[i], t_b[i], t_upd[i]);
      check("tbl_last_result", result, 32'h0);
      check("tbl_last_status", status, 4'b1110);

      // Backpressure: the result is held, then a drain and an accept happen on the same edge.
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(EOR, 32'hF0F00000, 32'h0FF000FF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_result", result, 32'hFF0000FF);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid = 1'b1; op_code = ORR; a_in = 32'h12; b_in = 32'h21;
      #1;
      check("drain_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("drain_out_valid", out_valid, 1'b1);
      check("drain_result", result, 32'h33);

      // Multiply op. The flags are set to C=1, V=0 beforehand so C/V pass-through is visible.
      issue(ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
      issue(MUL, 32'h10000, 32'h10000, 1'b1);
`ifdef ALU_PIPE_MUL_EN
      nb = 0;
      while (busy && nb < 200) begin
         nb++;
         @(posedge clk); #1;
      end
      check("mul_busy_cycles", nb, 32);
      check("mul_result", result, 32'h0);
      check("mul_status", status, 4'b1100);
`else
      check("mul_undef_valid", out_valid, 1'b1);
      check("mul_undef_result", result, 32'h0);
      check("mul_undef_status", status, 4'b1000);
`endif
      @(posedge clk); #1;
      issue(MUL, 32'h3, 32'h7, 1'b0);
      wait_idle(200);
      @(posedge clk); #1;

      // Reset in the middle of a multiply.
      issue(ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
      issue(MUL, 32'h1234, 32'h5678, 1'b1);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_flags", flags, 4'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_result_after_reset", seen, 0);

      // 8-bit SBC 0-0 with C clear gives a borrow: result 0xFF, status Z0 C0 V0 N1.
      @(posedge clk); #1;
      in_valid8 = 1'b1; op8 = SBC; a8 = 8'h00; b8 = 8'h00; upd8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      check("w8_sbc_valid", out_valid8, 1'b1);
      check("w8_sbc_result", result8, 8'hFF);
      check("w8_sbc_status", status8, 4'b0001);
      check("w8_flags_unchanged", flags8, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
